// File: rtl/countdown_timer.sv
// countdown_timer: presettable mm:ss count-down at 10 ms resolution with
// debounced push-keys, alarm flag and six active-low seven-segment digits.
// Optional build macro COUNTDOWN_BLINK_EN: blink all digits while in DONE.
module countdown_timer #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 10000000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_set_min,
  input  logic       key_set_sec,
  input  logic       key_start_pause,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       alarm,
  output logic       running
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Key order: 0 = set_sec, 1 = set_min, 2 = start_pause
  logic [2:0] key_raw;
  logic [2:0] press;
  assign key_raw = {key_start_pause, key_set_min, key_set_sec};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic [DW-1:0] deb_cnt_reg;

      // Synchronise the key, then count consecutive low cycles (saturating)
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg)
            deb_cnt_reg <= '0;
          else if (deb_cnt_reg != DEB_MAX)
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
        end
      end

      // One pulse on the cycle the counter steps onto DEBOUNCE_CYCLES
      assign press[gi] = !sync2_reg && (deb_cnt_reg == DEB_LAST);
    end
  endgenerate

  logic ev_start, ev_min, ev_sec;
  assign ev_start = press[2];
  assign ev_min   = press[1] & ~press[2];
  assign ev_sec   = press[0] & ~press[1] & ~press[2];

  state_t        state_reg;
  logic [TW-1:0] tick_reg;
  logic [3:0]    pmin_t_reg, pmin_u_reg, psec_t_reg, psec_u_reg;
  logic [3:0]    min_t_reg, min_u_reg, sec_t_reg, sec_u_reg, cs_t_reg, cs_u_reg;

  logic [3:0] pmin_t_next, pmin_u_next, psec_t_next, psec_u_next;
  logic [3:0] min_t_next, min_u_next, sec_t_next, sec_u_next, cs_t_next, cs_u_next;
  logic       count_zero, dec_zero;

  // Preset increment with BCD wrap 99->00 (minutes) and 59->00 (seconds)
  always_comb begin
    pmin_u_next = pmin_u_reg + 4'd1;
    pmin_t_next = pmin_t_reg;
    if (pmin_u_reg == 4'd9) begin
      pmin_u_next = 4'd0;
      pmin_t_next = (pmin_t_reg == 4'd9) ? 4'd0 : pmin_t_reg + 4'd1;
    end
    psec_u_next = psec_u_reg + 4'd1;
    psec_t_next = psec_t_reg;
    if (psec_u_reg == 4'd9) begin
      psec_u_next = 4'd0;
      psec_t_next = (psec_t_reg == 4'd5) ? 4'd0 : psec_t_reg + 4'd1;
    end
  end

  // One-centisecond BCD decrement with borrow chain cs -> ss -> mm
  always_comb begin
    logic b;
    b          = (cs_u_reg == 4'd0);
    cs_u_next  = b ? 4'd9 : cs_u_reg - 4'd1;
    cs_t_next  = cs_t_reg;
    sec_u_next = sec_u_reg;
    sec_t_next = sec_t_reg;
    min_u_next = min_u_reg;
    min_t_next = min_t_reg;
    if (b) begin
      b         = (cs_t_reg == 4'd0);
      cs_t_next = b ? 4'd9 : cs_t_reg - 4'd1;
    end
    if (b) begin
      b          = (sec_u_reg == 4'd0);
      sec_u_next = b ? 4'd9 : sec_u_reg - 4'd1;
    end
    if (b) begin
      b          = (sec_t_reg == 4'd0);
      sec_t_next = b ? 4'd5 : sec_t_reg - 4'd1;
    end
    if (b) begin
      b          = (min_u_reg == 4'd0);
      min_u_next = b ? 4'd9 : min_u_reg - 4'd1;
    end
    if (b)
      min_t_next = min_t_reg - 4'd1;
    dec_zero   = ({min_t_next, min_u_next, sec_t_next, sec_u_next, cs_t_next, cs_u_next} == 24'd0);
    count_zero = ({min_t_reg, min_u_reg, sec_t_reg, sec_u_reg, cs_t_reg, cs_u_reg} == 24'd0);
  end

  // Main FSM: preset editing, tick timing, count, alarm and running flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      pmin_t_reg <= 4'd0; pmin_u_reg <= 4'd0; psec_t_reg <= 4'd0; psec_u_reg <= 4'd0;
      min_t_reg  <= 4'd0; min_u_reg  <= 4'd0; sec_t_reg  <= 4'd0; sec_u_reg  <= 4'd0;
      cs_t_reg   <= 4'd0; cs_u_reg   <= 4'd0;
      alarm      <= 1'b0;
      running    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ev_start) begin
            if (!count_zero) begin
              state_reg <= RUN;
              running   <= 1'b1;
              tick_reg  <= '0;
            end
          end else if (ev_min) begin
            pmin_t_reg <= pmin_t_next; pmin_u_reg <= pmin_u_next;
            min_t_reg  <= pmin_t_next; min_u_reg  <= pmin_u_next;
            sec_t_reg  <= psec_t_reg;  sec_u_reg  <= psec_u_reg;
            cs_t_reg   <= 4'd0;        cs_u_reg   <= 4'd0;
          end else if (ev_sec) begin
            psec_t_reg <= psec_t_next; psec_u_reg <= psec_u_next;
            sec_t_reg  <= psec_t_next; sec_u_reg  <= psec_u_next;
            min_t_reg  <= pmin_t_reg;  min_u_reg  <= pmin_u_reg;
            cs_t_reg   <= 4'd0;        cs_u_reg   <= 4'd0;
          end
        end
        RUN: begin
          if (ev_start) begin
            state_reg <= PAUSE;
            running   <= 1'b0;
          end else if (tick_reg == TICK_LAST) begin
            tick_reg  <= '0;
            min_t_reg <= min_t_next; min_u_reg <= min_u_next;
            sec_t_reg <= sec_t_next; sec_u_reg <= sec_u_next;
            cs_t_reg  <= cs_t_next;  cs_u_reg  <= cs_u_next;
            if (dec_zero) begin
              state_reg <= DONE;
              running   <= 1'b0;
              alarm     <= 1'b1;
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        PAUSE: begin
          if (ev_start) begin
            state_reg <= RUN;
            running   <= 1'b1;
          end
        end
        DONE: begin
          if (ev_start) begin
            state_reg <= IDLE;
            alarm     <= 1'b0;
            min_t_reg <= pmin_t_reg; min_u_reg <= pmin_u_reg;
            sec_t_reg <= psec_t_reg; sec_u_reg <= psec_u_reg;
            cs_t_reg  <= 4'd0;       cs_u_reg  <= 4'd0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic blank;
`ifdef COUNTDOWN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;

  // Blink phase: starts "on" at DONE entry, toggles every BLINK_DIV cycles
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != DONE) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= ~blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end
  assign blank = (state_reg == DONE) && !blink_on_reg;
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Segment drivers follow the count one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex5 <= 7'b1000000; hex4 <= 7'b1000000; hex3 <= 7'b1000000;
      hex2 <= 7'b1000000; hex1 <= 7'b1000000; hex0 <= 7'b1000000;
    end else if (blank) begin
      hex5 <= 7'b1111111; hex4 <= 7'b1111111; hex3 <= 7'b1111111;
      hex2 <= 7'b1111111; hex1 <= 7'b1111111; hex0 <= 7'b1111111;
    end else begin
      hex5 <= seg7(min_t_reg); hex4 <= seg7(min_u_reg);
      hex3 <= seg7(sec_t_reg); hex2 <= seg7(sec_u_reg);
      hex1 <= seg7(cs_t_reg);  hex0 <= seg7(cs_u_reg);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven vectors plus hand-written run/pause/done
// sequences; expectations go through a scoreboard queue.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] keys_n;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       alarm, running;

  countdown_timer #(.TICK_DIV(2), .DEBOUNCE_CYCLES(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_set_min(keys_n[1]), .key_set_sec(keys_n[0]), .key_start_pause(keys_n[2]),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .alarm(alarm), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {OP_WAIT, OP_START, OP_MIN, OP_SEC, OP_HOLD_MIN} op_t;
  typedef struct {
    op_t         op;
    int          reps;
    logic [23:0] digits;
    bit          alarm;
    bit          running;
    string       name;
  } vec_t;
  typedef struct {
    logic [23:0] digits;
    bit          alarm;
    bit          running;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;  4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;  4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;  4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;  4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;  4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] d);
    exp_hex = {seg(d[23:20]), seg(d[19:16]), seg(d[15:12]),
               seg(d[11:8]), seg(d[7:4]), seg(d[3:0])};
  endfunction

  // Total centiseconds -> BCD mm:ss.cc
  function automatic logic [23:0] to_digits(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    to_digits = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [23:0] d, input bit a, input bit r, input string n);
    exp_t e;
    e.digits = d; e.alarm = a; e.running = r; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    logic [41:0] act;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got no expectation, need one");
    end else begin
      e = sb.pop_front();
      act = {hex5, hex4, hex3, hex2, hex1, hex0};
      checks++;
      if (act !== exp_hex(e.digits)) begin
        errors++;
        $display("FAIL %s hex: got %h want %h (digits %h)", e.name, act, exp_hex(e.digits), e.digits);
      end
      checks++;
      if (alarm !== e.alarm) begin
        errors++;
        $display("FAIL %s alarm: got %b want %b", e.name, alarm, e.alarm);
      end
      checks++;
      if (running !== e.running) begin
        errors++;
        $display("FAIL %s running: got %b want %b", e.name, running, e.running);
      end
      $display("check %-16s hex=%h alarm=%b running=%b", e.name, act, alarm, running);
    end
  endtask

  task automatic press(input int idx, input int hold);
    keys_n[idx] = 1'b0;
    repeat (hold) tick();
    keys_n[idx] = 1'b1;
    repeat (8) tick();
  endtask

  // Hold start low until running reaches want; report press and hit cycles
  task automatic start_until(input bit want, output int t_begin, output int t_hit);
    bit hit;
    hit = 1'b0;
    t_begin = cyc;
    t_hit = cyc;
    keys_n[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (running === want) begin
        hit = 1'b1;
        t_hit = cyc;
        break;
      end
    end
    keys_n[2] = 1'b1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL start_until: running got %b want %b within 30 cycles", running, want);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    push_exp(v.digits, v.alarm, v.running, v.name);
    case (v.op)
      OP_WAIT:     repeat (v.reps) tick();
      OP_START:    repeat (v.reps) press(2, 10);
      OP_MIN:      repeat (v.reps) press(1, 10);
      OP_SEC:      repeat (v.reps) press(0, 10);
      OP_HOLD_MIN: press(1, v.reps);
      default:     tick();
    endcase
    check_front();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   c0, s_hit, p_hit, r_hit, lat, k, paused;

    vecs[0] = '{OP_WAIT,      1, 24'h000000, 1'b0, 1'b0, "idle_after_rst"};
    vecs[1] = '{OP_START,     1, 24'h000000, 1'b0, 1'b0, "start_at_zero"};
    vecs[2] = '{OP_SEC,       3, 24'h000300, 1'b0, 1'b0, "sec_x3"};
    vecs[3] = '{OP_SEC,      56, 24'h005900, 1'b0, 1'b0, "sec_to_59"};
    vecs[4] = '{OP_SEC,       1, 24'h000000, 1'b0, 1'b0, "sec_wrap"};
    vecs[5] = '{OP_HOLD_MIN, 20, 24'h010000, 1'b0, 1'b0, "min_hold20"};
    vecs[6] = '{OP_MIN,      98, 24'h990000, 1'b0, 1'b0, "min_to_99"};
    vecs[7] = '{OP_MIN,       1, 24'h000000, 1'b0, 1'b0, "min_wrap"};
    vecs[8] = '{OP_SEC,       1, 24'h000100, 1'b0, 1'b0, "preset_0001"};

    rst_n  = 1'b0;
    keys_n = 3'b111;
    repeat (3) tick();
    push_exp(24'h000000, 1'b0, 1'b0, "reset_state");
    check_front();
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // 00:01 run to zero
    start_until(1'b1, c0, s_hit);
    repeat (3) tick();
    push_exp(24'h000099, 1'b0, 1'b1, "first_tick");
    check_front();
    repeat (196) tick();
    push_exp(24'h000001, 1'b0, 1'b1, "last_cs");
    check_front();
    tick();
    push_exp(24'h000001, 1'b1, 1'b0, "done_entry");
    check_front();
    tick();
    push_exp(24'h000000, 1'b1, 1'b0, "done_hex");
    check_front();
    repeat (3) tick();
`ifdef COUNTDOWN_BLINK_EN
    push_exp(24'hFFFFFF, 1'b1, 1'b0, "done_blink_off");
`else
    push_exp(24'h000000, 1'b1, 1'b0, "done_steady1");
`endif
    check_front();
    repeat (3) tick();
    push_exp(24'h000000, 1'b1, 1'b0, "done_on_again");
    check_front();

    // acknowledge reloads preset
    push_exp(24'h000100, 1'b0, 1'b0, "done_ack");
    press(2, 10);
    check_front();

    // preset 01:00
    push_exp(24'h000000, 1'b0, 1'b0, "sec_back_00");
    repeat (59) press(0, 10);
    check_front();
    push_exp(24'h010000, 1'b0, 1'b0, "preset_0100");
    press(1, 10);
    check_front();

    // borrow chain, pause and resume
    start_until(1'b1, c0, s_hit);
    lat = s_hit - c0;
    repeat (3) tick();
    push_exp(24'h005999, 1'b0, 1'b1, "borrow_chain");
    check_front();
    repeat (6) tick();
    if (((cyc + lat - s_hit) % 2) == 0) tick();
    start_until(1'b0, c0, p_hit);
    k = (p_hit - 1 - s_hit) / 2;
    paused = 6000 - k;
    repeat (2) tick();
    push_exp(to_digits(paused), 1'b0, 1'b0, "pause_hold");
    check_front();
    repeat (50) tick();
    push_exp(to_digits(paused), 1'b0, 1'b0, "pause_hold50");
    check_front();
    start_until(1'b1, c0, r_hit);
    repeat (11) tick();
    push_exp(to_digits(paused - 5), 1'b0, 1'b1, "resume_5ticks");
    check_front();

    // reset in RUN with a start key held low in the same cycle
    rst_n = 1'b0;
    keys_n[2] = 1'b0;
    tick();
    push_exp(24'h000000, 1'b0, 1'b0, "reset_mid_run");
    check_front();
    rst_n = 1'b1;
    keys_n[2] = 1'b1;
    repeat (5) tick();
    push_exp(24'h000000, 1'b0, 1'b0, "post_reset_idle");
    check_front();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
